// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus: write strobe/data from the UART receiver, show-ahead read port and status.
// The slave modport is the FIFO side; the master modport is the receiver/host side.
`timescale 1ns/1ps
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
);
    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rd_en;
    logic                 clr_overrun;
    logic [DATA_BITS-1:0] rd_data;
    logic                 empty;
    logic                 full;
    logic [ADDR_BITS:0]   count;
    logic                 overrun;

    modport master (
        output rx_done, rx_data, rd_en, clr_overrun,
        input  rd_data, empty, full, count, overrun
    );

    modport slave (
        input  rx_done, rx_data, rd_en, clr_overrun,
        output rd_data, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO with show-ahead read, fill level and sticky overrun flag.
// Define UART_RX_FIFO_OVERWRITE_EN to overwrite the oldest byte on overrun instead of dropping the new one.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int                 DEPTH    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_overrun;

    logic w_empty;
    logic w_full;
    logic w_wr;
    logic w_rd;
    logic w_ovf;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_wr    = bus.rx_done & (~w_full | bus.rd_en);
    assign w_rd    = bus.rd_en & ~w_empty;
    assign w_ovf   = bus.rx_done & w_full & ~bus.rd_en;

`ifdef UART_RX_FIFO_OVERWRITE_EN
    // Overrun behaves like a simultaneous push and pop: oldest byte is discarded.
    assign w_push = w_wr | w_ovf;
    assign w_pop  = w_rd | w_ovf;
`else
    assign w_push = w_wr;
    assign w_pop  = w_rd;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // Set has priority over clear so a same-cycle overrun is never lost.
            if (w_ovf) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.rd_data = r_mem[r_rd_ptr];
    assign bus.empty   = w_empty;
    assign bus.full    = w_full;
    assign bus.count   = r_count;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model predicts status and popped bytes.
// Honours UART_RX_FIFO_OVERWRITE_EN the same way the design does.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int DB = 8;
    localparam int AB = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic [7:0] model_q [$];
    logic       model_ovr;
    logic [7:0] exp_q [$];

    uart_rx_fifo_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus ();

    uart_rx_fifo #(.DATA_BITS(DB), .ADDR_BITS(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        check("count",   32'(bus.count),   32'(model_q.size()));
        check("empty",   32'(bus.empty),   32'(model_q.size() == 0));
        check("full",    32'(bus.full),    32'(model_q.size() == DEPTH));
        check("overrun", 32'(bus.overrun), 32'(model_ovr));
    endtask

    // Drive one cycle of inputs and advance the model to its post-edge state.
    task automatic step(input logic rxd, input logic [7:0] d, input logic rd, input logic clr);
        bit is_full;
        bit is_empty;
        @(posedge clk);
        #1;
        check_status();
        bus.rx_done     = rxd;
        bus.rx_data     = d;
        bus.rd_en       = rd;
        bus.clr_overrun = clr;
        is_full  = (model_q.size() == DEPTH);
        is_empty = (model_q.size() == 0);
        if (rd && !is_empty) begin
            exp_q.push_back(model_q.pop_front());
        end
        if (rxd && (!is_full || rd)) begin
            model_q.push_back(d);
        end
        if (rxd && is_full && !rd) begin
            model_ovr = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
            void'(model_q.pop_front());
            model_q.push_back(d);
`endif
        end else if (clr) begin
            model_ovr = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
    endtask

    // Monitor: every accepted pop must present the next expected byte.
    always @(negedge clk) begin
        if (rst && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_data: unexpected pop of 0x%0h at %0t", bus.rd_data, $time);
            end else begin
                check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] wdata;
        int         nwr;
        n_checks        = 0;
        n_pass          = 0;
        model_ovr       = 1'b0;
        bus.rx_done     = 1'b0;
        bus.rx_data     = '0;
        bus.rd_en       = 1'b0;
        bus.clr_overrun = 1'b0;
        rst = 1'b0;
        #12;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        rst = 1'b1;

        // Single byte in and out
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);

        // Empty with rd_en alone, then empty with simultaneous write and read
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        idle(1);
        drain();

        // Fill to full and drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        idle(1);
        drain();

        // Overrun on a full FIFO
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        idle(1);
        drain();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        idle(1);
        drain();

        // Pointer wrap: 40 bytes of incrementing data, random gaps and reads
        nwr   = 0;
        wdata = 8'h80;
        while (nwr < 40) begin
            if ($urandom_range(0, 2) != 0) begin
                step(1'b1, wdata, 1'($urandom_range(0, 1)), 1'b0);
                wdata++;
                nwr++;
            end else begin
                step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        drain();

        // Fully random traffic including overruns and clears
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 7) == 0));
        end
        drain();

        // Overrun and clear on the same edge: set wins
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        idle(1);

        // Asynchronous reset mid-sequence with count=7 and overrun=1
        drain();
        step(1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        @(posedge clk);
        #3;
        check("pre_rst_count", 32'(bus.count), 32'd7);
        check("pre_rst_ovr",   32'(bus.overrun), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_count",   32'(bus.count),   32'd0);
        check("arst_empty",   32'(bus.empty),   32'd1);
        check("arst_full",    32'(bus.full),    32'd0);
        check("arst_overrun", 32'(bus.overrun), 32'd0);
        model_q.delete();
        model_ovr = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        idle(2);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        drain();

        check("scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
